// File: rtl/cmd_arbiter_seq.sv
// Two-requester round-robin command sequencer driving a shared increment/accumulate register.
// Optional watchdog abort on prolonged datapath stall is enabled by defining CMD_WATCHDOG_EN.
module cmd_arbiter_seq #(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 8
`ifdef CMD_WATCHDOG_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic              iClock,
  input  logic              Reset,
  input  logic              iReq0Valid,
  input  logic [STEP_W-1:0] iReq0Step,
  output logic              oReq0Ready,
  input  logic              iReq1Valid,
  input  logic [STEP_W-1:0] iReq1Step,
  output logic              oReq1Ready,
  input  logic              iClear,
  input  logic              iStall,
  output logic [WIDTH-1:0]  oAccum,
  output logic              oBusy,
  output logic              oDone,
  output logic              oDoneId,
  output logic              oError,
  output logic              oInitDone
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IDLE  = 3'd1,
    S_ADD   = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_accum;
  logic [STEP_W-1:0]   r_remain;
  logic                r_id;
  logic                r_rr;
  logic                r_busy;
  logic                r_done;
  logic                r_done_id;
  logic                r_init;

  logic                w_open;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_accept;
  logic [STEP_W-1:0]   w_step;

  // Grants only in IDLE with no clear pending; rr pointer breaks ties.
  assign w_open   = (r_state == S_IDLE) && !iClear;
  assign w_gnt0   = w_open && iReq0Valid && (!iReq1Valid || !r_rr);
  assign w_gnt1   = w_open && iReq1Valid && (!iReq0Valid ||  r_rr);
  assign w_accept = w_gnt0 || w_gnt1;
  assign w_step   = w_gnt1 ? iReq1Step : iReq0Step;

  assign oReq0Ready = w_gnt0;
  assign oReq1Ready = w_gnt1;
  assign oAccum     = r_accum;
  assign oBusy      = r_busy;
  assign oDone      = r_done;
  assign oDoneId    = r_done_id;
  assign oInitDone  = r_init;

`ifdef CMD_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_stall_cnt;
  logic [CW-1:0] w_stall_nxt;
  logic          r_err_pend;
  logic          r_error;
  assign w_stall_nxt = r_stall_cnt + CW'(1);
  assign oError      = r_error;
`else
  assign oError = 1'b0;
`endif

  always_ff @(posedge iClock) begin
    if (Reset) begin
      r_state   <= S_RESET;
      r_accum   <= '0;
      r_remain  <= '0;
      r_id      <= 1'b0;
      r_rr      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_init    <= 1'b0;
`ifdef CMD_WATCHDOG_EN
      r_stall_cnt <= '0;
      r_err_pend  <= 1'b0;
      r_error     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_busy <= (r_state == S_ADD) || (r_state == S_DONE) || w_accept;
`ifdef CMD_WATCHDOG_EN
      r_error <= 1'b0;
`endif
      case (r_state)
        S_RESET: begin
          r_state <= S_IDLE;
          r_init  <= 1'b1;
        end
        S_IDLE: begin
          if (iClear) begin
            r_accum <= '0;
          end else if (w_accept) begin
            r_id     <= w_gnt1;
            r_rr     <= ~w_gnt1;
            r_remain <= w_step;
            r_state  <= (w_step == '0) ? S_DONE : S_ADD;
`ifdef CMD_WATCHDOG_EN
            r_stall_cnt <= '0;
            r_err_pend  <= 1'b0;
`endif
          end
        end
        S_ADD: begin
          if (!iStall) begin
            r_accum  <= r_accum + WIDTH'(1);
            r_remain <= r_remain - STEP_W'(1);
            if (r_remain == STEP_W'(1)) r_state <= S_DONE;
`ifdef CMD_WATCHDOG_EN
            r_stall_cnt <= '0;
          end else begin
            // Abort keeps the partial accumulator value.
            r_stall_cnt <= w_stall_nxt;
            if (w_stall_nxt == CW'(TIMEOUT)) begin
              r_state    <= S_DONE;
              r_err_pend <= 1'b1;
            end
`endif
          end
        end
        S_DONE: begin
          r_done    <= 1'b1;
          r_done_id <= r_id;
          r_state   <= S_IDLE;
`ifdef CMD_WATCHDOG_EN
          r_error   <= r_err_pend;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_arbiter_seq.sv
// Directed bench for cmd_arbiter_seq; a narrow second instance exercises accumulator wrap.
module tb_cmd_arbiter_seq;

  logic        iClock;
  logic        Reset;
  logic        iReq0Valid, iReq1Valid, iClear, iStall;
  logic [7:0]  iReq0Step, iReq1Step;
  logic        oReq0Ready, oReq1Ready, oBusy, oDone, oDoneId, oError, oInitDone;
  logic [31:0] oAccum;

  logic        wValid0, wValid1, wClear, wStall;
  logic [7:0]  wStep0, wStep1;
  logic        wReady0, wReady1, wBusy, wDone, wDoneId, wError, wInit;
  logic [3:0]  wAcc;

  int n_chk = 0;
  int n_fail = 0;

  cmd_arbiter_seq dut (
    .iClock(iClock), .Reset(Reset),
    .iReq0Valid(iReq0Valid), .iReq0Step(iReq0Step), .oReq0Ready(oReq0Ready),
    .iReq1Valid(iReq1Valid), .iReq1Step(iReq1Step), .oReq1Ready(oReq1Ready),
    .iClear(iClear), .iStall(iStall), .oAccum(oAccum), .oBusy(oBusy),
    .oDone(oDone), .oDoneId(oDoneId), .oError(oError), .oInitDone(oInitDone)
  );

  cmd_arbiter_seq #(.WIDTH(4)) dut_w (
    .iClock(iClock), .Reset(Reset),
    .iReq0Valid(wValid0), .iReq0Step(wStep0), .oReq0Ready(wReady0),
    .iReq1Valid(wValid1), .iReq1Step(wStep1), .oReq1Ready(wReady1),
    .iClear(wClear), .iStall(wStall), .oAccum(wAcc), .oBusy(wBusy),
    .oDone(wDone), .oDoneId(wDoneId), .oError(wError), .oInitDone(wInit)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; iClear = 1'b0; iStall = 1'b0;
    iReq0Valid = 1'b1; iReq0Step = 8'd5; iReq1Valid = 1'b0; iReq1Step = 8'd0;
    wValid0 = 1'b0; wValid1 = 1'b0; wStep0 = 8'd0; wStep1 = 8'd0; wClear = 1'b0; wStall = 1'b0;

    // Reset state
    repeat (3) step();
    chkb("rst_init", oInitDone, 1'b0);
    chk ("rst_accum", oAccum, 32'd0);
    chkb("rst_ready0", oReq0Ready, 1'b0);
    chkb("rst_busy", oBusy, 1'b0);
    chkb("rst_done", oDone, 1'b0);
    Reset = 1'b0;
    #1;
    chkb("resetstate_ready0", oReq0Ready, 1'b0);
    step();
    chkb("init_set", oInitDone, 1'b1);
    chk ("init_accum", oAccum, 32'd0);
    chkb("idle_ready0", oReq0Ready, 1'b1);
    chkb("idle_ready1", oReq1Ready, 1'b0);

    // Single command, N=5
    step();
    iReq0Valid = 1'b0;
    #1;
    chkb("add_busy", oBusy, 1'b1);
    chkb("add_ready0", oReq0Ready, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk ("n5_accum", oAccum, 32'(k));
      chkb("n5_nodone", oDone, 1'b0);
    end
    step();
    chkb("n5_done", oDone, 1'b1);
    chkb("n5_doneid", oDoneId, 1'b0);
    chkb("n5_busy", oBusy, 1'b1);
    chkb("n5_err", oError, 1'b0);
    chk ("n5_final", oAccum, 32'd5);
    step();
    chkb("n5_done_pulse", oDone, 1'b0);
    chkb("n5_busy_off", oBusy, 1'b0);

    // Both requesters from reset, round robin
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
    iReq0Valid = 1'b1; iReq0Step = 8'd2; iReq1Valid = 1'b1; iReq1Step = 8'd2;
    #1;
    chk ("rr_accum0", oAccum, 32'd0);
    chkb("rr_first_r0", oReq0Ready, 1'b1);
    chkb("rr_first_r1", oReq1Ready, 1'b0);
    step();
    chkb("rr_wait_r0", oReq0Ready, 1'b0);
    chkb("rr_wait_r1", oReq1Ready, 1'b0);
    step(); chk("rr_acc1", oAccum, 32'd1);
    step(); chk("rr_acc2", oAccum, 32'd2);
    step();
    chkb("rr_done0", oDone, 1'b1);
    chkb("rr_id0", oDoneId, 1'b0);
    chkb("rr_second_r1", oReq1Ready, 1'b1);
    chkb("rr_second_r0", oReq0Ready, 1'b0);
    step();
    iReq0Valid = 1'b0; iReq1Valid = 1'b0;
    chkb("rr_done_drop", oDone, 1'b0);
    step(); chk("rr_acc3", oAccum, 32'd3);
    step(); chk("rr_acc4", oAccum, 32'd4);
    step();
    chkb("rr_done1", oDone, 1'b1);
    chkb("rr_id1", oDoneId, 1'b1);
    chk ("rr_final", oAccum, 32'd4);
    step();

    // Req1 N=4 with 3 stall cycles; clear ignored while busy
    iReq1Valid = 1'b1; iReq1Step = 8'd4;
    #1;
    chkb("st_ready1", oReq1Ready, 1'b1);
    step();
    iReq1Valid = 1'b0;
    step(); chk("st_acc5", oAccum, 32'd5);
    step(); chk("st_acc6", oAccum, 32'd6);
    iStall = 1'b1; iClear = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk ("st_hold", oAccum, 32'd6);
      chkb("st_nodone", oDone, 1'b0);
    end
    iStall = 1'b0; iClear = 1'b0;
    step(); chk("st_acc7", oAccum, 32'd7);
    step(); chk("st_acc8", oAccum, 32'd8);
    chkb("st_late", oDone, 1'b0);
    step();
    chkb("st_done", oDone, 1'b1);
    chkb("st_id", oDoneId, 1'b1);
    chk ("st_final", oAccum, 32'd8);
    step();

    // N=0 goes straight to DONE
    iReq0Valid = 1'b1; iReq0Step = 8'd0;
    #1;
    chkb("n0_ready0", oReq0Ready, 1'b1);
    step();
    iReq0Valid = 1'b0;
    chkb("n0_busy", oBusy, 1'b1);
    chkb("n0_nodone", oDone, 1'b0);
    step();
    chkb("n0_done", oDone, 1'b1);
    chkb("n0_id", oDoneId, 1'b0);
    chk ("n0_accum", oAccum, 32'd8);
    step();

    // Wrap on the 4-bit instance: 14 then +3 -> 1, then clear
    wValid0 = 1'b1; wStep0 = 8'd14;
    #1;
    chkb("w_ready", wReady0, 1'b1);
    step();
    wValid0 = 1'b0;
    repeat (14) step();
    step();
    chkb("w_done14", wDone, 1'b1);
    chk ("w_acc14", 32'(wAcc), 32'd14);
    wValid0 = 1'b1; wStep0 = 8'd3;
    step();
    wValid0 = 1'b0;
    step(); chk("w_acc15", 32'(wAcc), 32'd15);
    step(); chk("w_wrap0", 32'(wAcc), 32'd0);
    step(); chk("w_wrap1", 32'(wAcc), 32'd1);
    step();
    chkb("w_done3", wDone, 1'b1);
    wClear = 1'b1; wValid0 = 1'b1; wStep0 = 8'd2;
    #1;
    chkb("w_clear_noready", wReady0, 1'b0);
    step();
    wClear = 1'b0; wValid0 = 1'b0;
    chk ("w_cleared", 32'(wAcc), 32'd0);
    chkb("w_clear_nobusy", wBusy, 1'b0);

`ifdef CMD_WATCHDOG_EN
    // Watchdog abort after 16 consecutive stalls
    iReq0Valid = 1'b1; iReq0Step = 8'd3;
    step();
    iReq0Valid = 1'b0; iStall = 1'b1;
    repeat (15) step();
    chkb("wd_busy", oBusy, 1'b1);
    chkb("wd_nodone15", oDone, 1'b0);
    step();
    chkb("wd_nodone16", oDone, 1'b0);
    step();
    chkb("wd_done", oDone, 1'b1);
    chkb("wd_err", oError, 1'b1);
    chk ("wd_accum", oAccum, 32'd8);
    iStall = 1'b0;
    step();
    chkb("wd_err_pulse", oError, 1'b0);
`endif

    // Reset mid-command aborts silently
    iReq0Valid = 1'b1; iReq0Step = 8'd3;
    step();
    iReq0Valid = 1'b0;
    step();
    chk("ra_acc9", oAccum, 32'd9);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chkb("ra_init", oInitDone, 1'b0);
    chkb("ra_busy", oBusy, 1'b0);
    chk ("ra_accum", oAccum, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chkb("ra_nodone", oDone, 1'b0);
      chkb("ra_noerr", oError, 1'b0);
    end
    chkb("ra_init_again", oInitDone, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
